// File: rtl/writeback_arbiter.sv
// writeback_arbiter: two-channel FIFO'd round-robin arbiter driving the register-file write port.
// Optional WB_BYPASS_EN forwards the write landing this cycle onto rs1_out/rs2_out.
module writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]        alu_value,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]        mem_value,
    output logic                     reg_write_en,
    output logic [REG_ADDR_W-1:0]    rd,
    output logic [DATA_W-1:0]        rd_value,
    output logic [2**REG_ADDR_W-1:0] pending_mask,
    output logic                     busy,
    input  logic [REG_ADDR_W-1:0]    rs1,
    input  logic [REG_ADDR_W-1:0]    rs2,
    input  logic [DATA_W-1:0]        rs1_in,
    input  logic [DATA_W-1:0]        rs2_in,
    output logic [DATA_W-1:0]        rs1_out,
    output logic [DATA_W-1:0]        rs2_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    logic [REG_ADDR_W-1:0] q_rd  [2][FIFO_DEPTH];
    logic [DATA_W-1:0]     q_val [2][FIFO_DEPTH];
    logic [PW-1:0]         wp [2];
    logic [PW-1:0]         rp [2];
    logic [CW-1:0]         cnt [2];
    logic [REG_ADDR_W-1:0] in_rd [2];
    logic [DATA_W-1:0]     in_val [2];
    logic [1:0]            valid, ready, req, gnt, push;
    logic                  ptr, sel;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0]     head_val;
    assign valid     = {mem_valid, alu_valid};
    assign in_rd[0]  = alu_rd;
    assign in_rd[1]  = mem_rd;
    assign in_val[0] = alu_value;
    assign in_val[1] = mem_value;
    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    // ready comes only from the registered count, so a full FIFO refuses even while popping
    always_comb begin
        ready = '0;
        req   = '0;
        for (int c = 0; c < 2; c++) begin
            ready[c] = cnt[c] < CW'(FIFO_DEPTH);
            req[c]   = cnt[c] != '0;
        end
        push     = valid & ready;
        gnt[0]   = req[0] && (!req[1] || !ptr);
        gnt[1]   = req[1] && (!req[0] || ptr);
        sel      = gnt[1];
        head_rd  = q_rd[sel][rp[sel]];
        head_val = q_val[sel][rp[sel]];
    end
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                q_rd[c][wp[c]]  <= in_rd[c];
                q_val[c][wp[c]] <= in_val[c];
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
            ptr          <= 1'b0;
            reg_write_en <= 1'b0;
            rd           <= '0;
            rd_value     <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wp[c] <= wp[c] + 1'b1;
                if (gnt[c]) rp[c] <= rp[c] + 1'b1;
                cnt[c] <= cnt[c] + CW'(push[c]) - CW'(gnt[c]);
            end
            if (&req) ptr <= ~ptr;
            reg_write_en <= |gnt && head_rd != '0;
            if (|gnt) begin
                rd       <= head_rd;
                rd_value <= head_val;
            end
        end
    end
    // pointers are power-of-two wide, so rp + i wraps for free
    always_comb begin
        pending_mask = '0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (CW'(i) < cnt[c]) pending_mask[q_rd[c][rp[c] + PW'(i)]] = 1'b1;
        if (reg_write_en) pending_mask[rd] = 1'b1;
        pending_mask[0] = 1'b0;
    end
    assign busy = req != '0 || reg_write_en;
`ifdef WB_BYPASS_EN
    assign rs1_out = (reg_write_en && rd == rs1 && rs1 != '0) ? rd_value : rs1_in;
    assign rs2_out = (reg_write_en && rd == rs2 && rs2 != '0) ? rd_value : rs2_in;
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign rs1_out   = rs1_in;
    assign rs2_out   = rs2_in;
`endif
endmodule
